aes_round_ctrl: RTL and testbench

//  Sequencer for the iterative AES-128 encryption datapath. Accepts one data

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_round_ctrl.sv | 125 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: beat type codes, round count, round-key address width.
// Also holds the round-controller state encoding.
// No logic; types and localparams only.
package aes_pkg;

  localparam logic [1:0] TYPE_KEY  = 2'b10;
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam int         AES_NR    = 10;
  localparam int         RK_ADDR_W = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_ROUND = 3'd2;
  localparam logic [2:0] ST_FINAL = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_INIT  = ST_INIT,
    S_ROUND = ST_ROUND,
    S_FINAL = ST_FINAL,
    S_HOLD  = ST_HOLD
  } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath: initial AddRoundKey, NR-1 rounds, final round.
// Latency: block accepted in cycle T gives out_valid at T+NR+2; one block per NR+3 cycles.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int         NR        = AES_NR,
  parameter int         ADDR_W    = RK_ADDR_W,
  parameter logic [1:0] TYPE_DATA = aes_pkg::TYPE_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_loaded,
  input  logic              in_valid,
  input  logic [1:0]        in_type,
  output logic              in_ready,
  output logic [ADDR_W-1:0] rk_addr,
  output logic              dp_load,
  output logic              dp_round,
  output logic              dp_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              abort,
  output logic              drop
);

  // Key addresses 1..NR+1 must fit, with 0 kept as "no key selected".
  if (NR + 1 > (2 ** ADDR_W) - 1) begin : g_addr_check
    $error("aes_round_ctrl: NR+1 does not fit in ADDR_W bits");
  end

  ctrl_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  // State and round counter registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and output decode; key loss in a compute state kills the block.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    rk_addr   = '0;
    dp_load   = 1'b0;
    dp_round  = 1'b0;
    dp_last   = 1'b0;
    out_valid = 1'b0;
    abort     = 1'b0;
    drop      = 1'b0;

    case (state)
      S_IDLE: begin
        in_ready = key_loaded;
        cnt_nxt  = '0;
        if (in_valid && key_loaded) begin
          if (in_type == TYPE_DATA) state_nxt = S_INIT;
          else                      drop      = 1'b1;
        end
      end
      S_INIT: begin
        rk_addr = ADDR_W'(1);
        if (!key_loaded) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          dp_load   = 1'b1;
          cnt_nxt   = ADDR_W'(2);
          state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        rk_addr = cnt;
        if (!key_loaded) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          dp_round = 1'b1;
          cnt_nxt  = cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(NR)) state_nxt = S_FINAL;
        end
      end
      S_FINAL: begin
        rk_addr = ADDR_W'(NR + 1);
        if (!key_loaded) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          dp_last   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // Result already computed, so key_loaded no longer matters here.
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Input-dependent outputs stay quiet while reset is applied.
    if (rst) begin
      in_ready = 1'b0;
      abort    = 1'b0;
      drop     = 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed scenarios plus randomized traffic.
// Latency: a block is tracked by its position in the cipher schedule.
// Backpressure: out_ready and key_loaded are randomized.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int NR = AES_NR;
  localparam int AW = RK_ADDR_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_loaded;
  logic          in_valid;
  logic [1:0]    in_type;
  logic          in_ready;
  logic [AW-1:0] rk_addr;
  logic          dp_load, dp_round, dp_last;
  logic          out_valid;
  logic          out_ready;
  logic          abort, drop;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  aes_round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_loaded (key_loaded),
    .in_valid   (in_valid),
    .in_type    (in_type),
    .in_ready   (in_ready),
    .rk_addr    (rk_addr),
    .dp_load    (dp_load),
    .dp_round   (dp_round),
    .dp_last    (dp_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .abort      (abort),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pos 0 = idle, 1..NR+1 = step of the key schedule being
  // applied, NR+2 = ciphertext waiting for the consumer.
  int pos = 0;
  int pos_nxt;

  // Every cycle: predict all outputs from the schedule position, compare, advance.
  initial begin
    bit running, holding, idle, kl, typ_data;
    int e_rk;
    int e_vec, a_vec;
    forever begin
      @(negedge clk);
      running  = (pos >= 1) && (pos <= NR + 1);
      holding  = (pos == NR + 2);
      idle     = (pos == 0);
      kl       = key_loaded;
      typ_data = (in_type == TYPE_DATA);
      e_rk     = running ? pos : 0;
      e_vec = (e_rk << 7)
            | (int'(!rst && idle && kl) << 6)
            | (int'(running && kl && pos == 1) << 5)
            | (int'(running && kl && pos >= 2 && pos <= NR) << 4)
            | (int'(running && kl && pos == NR + 1) << 3)
            | (int'(holding) << 2)
            | (int'(!rst && running && !kl) << 1)
            | int'(!rst && idle && kl && in_valid && !typ_data);
      a_vec = (int'(rk_addr) << 7) | (int'(in_ready) << 6) | (int'(dp_load) << 5)
            | (int'(dp_round) << 4) | (int'(dp_last) << 3) | (int'(out_valid) << 2)
            | (int'(abort) << 1) | int'(drop);
      if (cmp_en) chk("model_outputs", a_vec, e_vec);

      if (rst)          pos_nxt = 0;
      else if (idle)    pos_nxt = (in_valid && kl && typ_data) ? 1 : 0;
      else if (running) pos_nxt = kl ? pos + 1 : 0;
      else              pos_nxt = out_ready ? 0 : pos;
      @(posedge clk);
      pos = pos_nxt;
    end
  end

  // Nominal block: accept now, walk the full key schedule, consumer ready.
  task automatic run_nominal(input string tag);
    int rounds;
    rounds     = 0;
    key_loaded = 1'b1;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_type    = TYPE_DATA;
    @(negedge clk);
    chk({tag, "_accept_ready"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_type  = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i <= 11) chk({tag, "_rk_addr"}, int'(rk_addr), i);
      if (i == 1)  chk({tag, "_dp_load"}, int'(dp_load), 1);
      if (i == 11) chk({tag, "_dp_last"}, int'(dp_last), 1);
      chk({tag, "_out_valid"}, int'(out_valid), (i == 12) ? 1 : 0);
      rounds += int'(dp_round);
      tick();
    end
    chk({tag, "_round_count"}, rounds, 9);
    @(negedge clk);
    chk({tag, "_back_idle"}, int'(in_ready), 1);
    chk({tag, "_ov_clear"}, int'(out_valid), 0);
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    key_loaded = 1'b0;
    in_valid   = 1'b0;
    in_type    = 2'b00;
    out_ready  = 1'b0;
    tick();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_rk_addr", int'(rk_addr), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    tick();
    rst = 1'b0;

    // Nominal sequence.
    run_nominal("t1");

    // Consumer stalls in HOLD.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_type   = TYPE_DATA;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_hold_valid", int'(out_valid), 1);
      chk("t2_hold_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_release_valid", int'(out_valid), 1);
    tick();
    @(negedge clk);
    chk("t2_after_valid", int'(out_valid), 0);
    chk("t2_after_in_ready", int'(in_ready), 1);
    tick();

    // No key schedule: beat waits, then is taken as soon as keys arrive.
    key_loaded = 1'b0;
    in_valid   = 1'b1;
    in_type    = TYPE_DATA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_nokey_in_ready", int'(in_ready), 0);
      chk("t3_nokey_rk_addr", int'(rk_addr), 0);
      tick();
    end
    key_loaded = 1'b1;
    @(negedge clk);
    chk("t3_key_in_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_dp_load", int'(dp_load), 1);
    repeat (12) tick();

    // Key lost mid-block.
    in_valid = 1'b1;
    in_type  = TYPE_DATA;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    key_loaded = 1'b0;
    @(negedge clk);
    chk("t4_abort", int'(abort), 1);
    chk("t4_no_round", int'(dp_round), 0);
    tick();
    @(negedge clk);
    chk("t4_idle_rk_addr", int'(rk_addr), 0);
    chk("t4_abort_once", int'(abort), 0);
    key_loaded = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t4_no_out_valid", int'(out_valid), 0);
      tick();
    end

    // Non-data beat is dropped.
    in_valid = 1'b1;
    in_type  = TYPE_KEY;
    @(negedge clk);
    chk("t5_drop", int'(drop), 1);
    chk("t5_rk_addr", int'(rk_addr), 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_drop_once", int'(drop), 0);
    chk("t5_no_load", int'(dp_load), 0);
    tick();

    // Reset mid-block, then a clean block.
    in_valid = 1'b1;
    in_type  = TYPE_DATA;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_no_abort", int'(abort), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rk_addr", int'(rk_addr), 0);
    chk("t6_strobes", int'({dp_load, dp_round, dp_last}), 0);
    chk("t6_out_valid", int'(out_valid), 0);
    tick();
    run_nominal("t6");

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom % 100) == 0;
      key_loaded = ($urandom % 20) != 0;
      in_valid   = $urandom % 2 == 1;
      in_type    = 2'($urandom % 4);
      out_ready  = ($urandom % 3) != 0;
      tick();
    end

    rst = 1'b1;
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
